// File: rtl/cla_pkg.sv
// Shared constants and parameter checking for the pipelined CLA adder.
package cla_pkg;

    localparam int GROUP_BITS = 4;

    // WIDTH must split into STAGES equal segments, each a whole number of 4-bit groups.
    function automatic bit cla_width_ok(input int width, input int stages);
        if (stages < 1 || width < GROUP_BITS) return 1'b0;
        if ((width % GROUP_BITS) != 0) return 1'b0;
        if (stages > (width / GROUP_BITS)) return 1'b0;
        return ((width % (GROUP_BITS * stages)) == 0);
    endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group: sum bits plus group propagate/generate.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_BITS-1:0] a,
    input  logic [GROUP_BITS-1:0] b,
    input  logic                  ci,
    output logic [GROUP_BITS-1:0] s,
    output logic                  gp,
    output logic                  gg,
    output logic                  co
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    // Bit propagate/generate, lookahead carries and group terms.
    always_comb begin
        w_p    = a ^ b;
        w_g    = a & b;
        w_c[0] = ci;
        w_c[1] = w_g[0] | (w_p[0] & ci);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & ci);
        gp     = &w_p;
        gg     = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        co     = gg | (gp & ci);
        s      = w_p ^ w_c;
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract: each stage adds one SEG-bit slice with 4-bit CLA groups,
// passing the slice carry forward through a register. Valid/ready handshake with
// a single global advance so a stalled output freezes the whole pipe.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = (STAGES > 0) ? (WIDTH / STAGES) : GROUP_BITS;
    localparam int NG  = SEG / GROUP_BITS;

    if (!cla_width_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_cla_adder: illegal WIDTH/STAGES combination");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_b_eff  = sub ? ~b : b;
    assign w_c0     = sub | cin;

    genvar k, j;
    for (k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO  = k * SEG;
        localparam int REM = WIDTH - LO;

        // Operand bits not yet summed, the carry into this slice, and the
        // lower result bits already finished by earlier stages.
        logic [REM-1:0]      w_a;
        logic [REM-1:0]      w_b;
        logic                w_ci;
        logic                w_vi;
        logic [LO+SEG-1:0]   w_s_nxt;
        logic [SEG-1:0]      w_seg_s;
        logic [NG:0]         w_gc;
        logic [NG-1:0]       w_gp;
        logic [NG-1:0]       w_gg;
        logic [NG-1:0]       w_unused_co;
        logic [LO+SEG-1:0]   r_s;
        logic                r_c;
        logic                r_v;

        if (k == 0) begin : g_src
            assign w_a     = a;
            assign w_b     = w_b_eff;
            assign w_ci    = w_c0;
            assign w_vi    = in_valid;
            assign w_s_nxt = w_seg_s;
        end else begin : g_src
            assign w_a     = g_stg[k-1].g_fwd.r_a;
            assign w_b     = g_stg[k-1].g_fwd.r_b;
            assign w_ci    = g_stg[k-1].r_c;
            assign w_vi    = g_stg[k-1].r_v;
            assign w_s_nxt = {w_seg_s, g_stg[k-1].r_s};
        end

        // Group carries ripple through the group P/G terms within the slice.
        assign w_gc[0] = w_ci;
        for (j = 0; j < NG; j++) begin : g_grp
            cla_group4 u_grp (
                .a  (w_a[j*GROUP_BITS +: GROUP_BITS]),
                .b  (w_b[j*GROUP_BITS +: GROUP_BITS]),
                .ci (w_gc[j]),
                .s  (w_seg_s[j*GROUP_BITS +: GROUP_BITS]),
                .gp (w_gp[j]),
                .gg (w_gg[j]),
                .co (w_unused_co[j])
            );
            assign w_gc[j+1] = w_gg[j] | (w_gp[j] & w_gc[j]);
        end

        // Stage valid, accumulated sum bits and slice carry-out.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_s <= '0;
                r_c <= 1'b0;
            end else if (w_adv) begin
                r_v <= w_vi;
                r_s <= w_s_nxt;
                r_c <= w_gc[NG];
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-SEG-1:0] r_a;
            logic [REM-SEG-1:0] r_b;

            // Upper operand slices wait here for their carry.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a[REM-1:SEG];
                    r_b <= w_b[REM-1:SEG];
                end
            end
        end else begin : g_last
            logic w_c_msb;
            logic r_ovf;

            // Carry into the MSB recovered from the MSB sum bit.
            assign w_c_msb = w_a[SEG-1] ^ w_b[SEG-1] ^ w_seg_s[SEG-1];

            // Signed overflow flag aligned with the final sum.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_c_msb ^ w_gc[NG];
                end
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].r_v;
    assign sum       = g_stg[STAGES-1].r_s;
    assign cout      = g_stg[STAGES-1].r_c;
    assign ovf       = g_stg[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench: driver pushes model results on input transfer, monitor pops on output transfer.
module tb_pipelined_cla_adder;

    localparam int W = 16;
    localparam int S = 4;
    localparam longint HALF = longint'(1) << (W - 1);
    localparam longint FULL = longint'(1) << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic         ovf;
        logic         cout;
        logic [W-1:0] sum;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_popped = 0;
    bit   last_rdy;

    // Reference: plain integer arithmetic on the operands as numbers.
    function automatic exp_t model(logic [W-1:0] fa, logic [W-1:0] fb, logic fcin, logic fsub);
        exp_t   e;
        longint bv, c0, full, sa, sb, ss;
        bv   = fsub ? (FULL - 1 - longint'(fb)) : longint'(fb);
        c0   = fsub ? 1 : longint'(fcin);
        full = longint'(fa) + bv + c0;
        e.sum  = W'(full % FULL);
        e.cout = ((full / FULL) % 2) == 1;
        sa = longint'(fa);
        if (sa >= HALF) sa = sa - FULL;
        sb = bv;
        if (sb >= HALF) sb = sb - FULL;
        ss = sa + sb + c0;
        e.ovf = (ss >= HALF) || (ss < -HALF);
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: sample handshake at negedge, push on acceptance, return just after posedge.
    task automatic cycle(output bit acc);
        @(negedge clk);
        last_rdy = in_ready;
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(a, b, cin, sub));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        a   = W'($urandom);
        b   = W'($urandom);
        if ($urandom_range(0, 7) == 0) a = (W'(1) << (W - 1)) - W'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) b = W'($urandom_range(0, 1)) ? '1 : '0;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    // Monitor: compare on every output transfer, and check holding while stalled.
    exp_t prev;
    bit   held = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", longint'(out_valid), 1);
                chk("hold_result", longint'({ovf, cout, sum}), longint'(prev));
            end
            if (out_valid && out_ready) begin
                n_popped++;
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", longint'(sum), longint'(e.sum));
                    chk("cout", longint'(cout), longint'(e.cout));
                    chk("ovf", longint'(ovf), longint'(e.ovf));
                end
            end
            held = out_valid && !out_ready;
            prev = '{ovf: ovf, cout: cout, sum: sum};
        end
    end

    task automatic directed(input string name, input logic [W-1:0] fa, input logic [W-1:0] fb,
                            input logic fcin, input logic fsub, input logic [W-1:0] esum,
                            input logic ecout, input logic eovf);
        bit acc;
        bit seen;
        int lat;
        a = fa; b = fb; cin = fcin; sub = fsub; in_valid = 1'b1;
        cycle(acc);
        chk({name, "_accept"}, longint'(acc), 1);
        in_valid = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                seen = 1'b1;
                chk({name, "_latency"}, lat, S);
                chk({name, "_sum"}, longint'(sum), longint'(esum));
                chk({name, "_cout"}, longint'(cout), longint'(ecout));
                chk({name, "_ovf"}, longint'(ovf), longint'(eovf));
            end
            @(posedge clk);
            #1;
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_drained"}, q.size(), 0);
    endtask

    initial begin
        bit acc;
        int sent;
        int pop0;
        int stale;
        bit seen;
        int cyc;

        // Reset state
        #3;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_sum", longint'(sum), 0);
        chk("rst_cout", longint'(cout), 0);
        chk("rst_ovf", longint'(ovf), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Boundary cases
        directed("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("neg_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed("cin_add", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
        directed("sub_ign_cin", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Back-to-back stream with a 3-cycle output stall
        sent = 0;
        pop0 = n_popped;
        rand_ops();
        for (int i = 0; i < 20; i++) begin
            in_valid  = (sent < 8);
            out_ready = !(i >= 5 && i < 8);
            cycle(acc);
            if (i >= 5 && i < 8) chk("stall_in_ready", longint'(last_rdy), 0);
            if (acc) begin
                sent++;
                rand_ops();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("stall", 20);
        chk("stall_sent", sent, 8);
        chk("stall_results", n_popped - pop0, 8);

        // Reset with transactions in flight
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            cycle(acc);
            chk("rst_tx_accept", longint'(acc), 1);
            a = a + 16'h0101;
        end
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
            @(posedge clk);
            #1;
        end
        chk("pre_rst_out_valid", longint'(seen), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", longint'(out_valid), 0);
        chk("async_rst_sum", longint'(sum), 0);
        chk("async_rst_cout", longint'(cout), 0);
        chk("async_rst_ovf", longint'(ovf), 0);
        chk("async_rst_in_ready", longint'(in_ready), 1);
        q.delete();
        @(negedge clk);
        chk("in_rst_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no_stale_after_rst", stale, 0);
        @(posedge clk);
        #1;

        // Random traffic with random bubbles and backpressure
        sent = 0;
        cyc  = 0;
        acc  = 1'b1;
        in_valid = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_ops();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(acc);
            if (acc) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("random_sent", sent, 10000);
        drain("random", 50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
